// File: rtl/conv_encoder.sv
// Rate-1/2 feed-forward convolutional encoder, constraint length K (fixed at 3).
// One information bit is consumed on every rising clock edge and one registered
// 2-bit code symbol is produced; there is no handshake, so stalls are done by
// gating upstream.
//
// Ports:
//   ck    in   1  clock, rising-edge active
//   rset  in   1  asynchronous active-low reset; clears state and symbol at once
//   bin   in   1  information bit, sampled on the rising edge of ck
//   cout  out  2  code symbol: cout[1] = G_HI parity, cout[0] = G_LO parity
//
// Generator tap ordering (MSB to LSB): {bin, s1, s2}, where s1 is the previous
// bin and s2 the bin two cycles ago. The trellis state index is {s1, s2}.
module conv_encoder #(
  parameter int unsigned   K    = 3,
  parameter logic [K-1:0]  G_HI = 3'b111,
  parameter logic [K-1:0]  G_LO = 3'b101
) (
  input  logic       ck,
  input  logic       rset,
  input  logic       bin,
  output logic [1:0] cout
);

  // Memory of the last K-1 input bits; MSB is s1 (most recent).
  logic [K-2:0] state_q, state_d;
  logic [1:0]   cout_q, cout_d;
  logic [K-1:0] taps;

  always_comb begin
    taps      = {bin, state_q};
    cout_d    = {^(taps & G_HI), ^(taps & G_LO)};
    // Shift toward the LSB: s2 <= s1, s1 <= bin.
    state_d   = taps[K-1:1];
  end

  always_ff @(posedge ck or negedge rset) begin
    if (!rset) begin
      state_q <= '0;
      cout_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      cout_q  <= cout_d;
    end
  end

  assign cout = cout_q;

endmodule

// File: tb/tb_conv_encoder.sv
// Self-checking bench for conv_encoder: a table of directed vectors (with reset
// pulses between sequences), hand-written reset corner cases, and a randomized
// run compared against a history-based reference model.
module tb_conv_encoder;

  logic       ck;
  logic       rset;
  logic       bin;
  logic [1:0] cout;

  int n_total;
  int n_pass;

  conv_encoder dut (
    .ck   (ck),
    .rset (rset),
    .bin  (bin),
    .cout (cout)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  // Hard time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  typedef struct {
    bit         rst_first;  // apply a reset pulse before this bit
    bit         b;
    logic [1:0] exp;
    string      name;
  } vec_t;

  // Reference model: the last two input bits, as plain integers.
  int h1, h2;

  function automatic logic [1:0] model_sym(input int b);
    int hi, lo;
    hi = (b + h1 + h2) % 2;  // generator 7 octal
    lo = (b + h2) % 2;       // generator 5 octal
    return {hi[0], lo[0]};
  endfunction

  task automatic check(input string name, input logic [1:0] got, input logic [1:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, got, exp);
  endtask

  // Called about 1 time unit after a rising edge.
  task automatic reset_pulse();
    rset = 1'b0;
    #1;
    h1 = 0;
    h2 = 0;
    repeat (2) begin
      bin = ~bin;
      @(posedge ck);
      #1;
    end
    rset = 1'b1;
  endtask

  task automatic step(input bit b, input string name, input logic [1:0] exp);
    bin = b;
    @(posedge ck);
    #1;
    check(name, cout, exp);
    h2 = h1;
    h1 = b;
  endtask

  vec_t vecs[$];

  initial begin
    n_total = 0;
    n_pass  = 0;
    h1 = 0;
    h2 = 0;
    rset = 1'b0;
    bin  = 1'b0;

    // Impulse response.
    vecs.push_back('{1'b1, 1'b1, 2'b11, "impulse0"});
    vecs.push_back('{1'b0, 1'b0, 2'b10, "impulse1"});
    vecs.push_back('{1'b0, 1'b0, 2'b11, "impulse2"});
    vecs.push_back('{1'b0, 1'b0, 2'b00, "impulse3"});
    // Known sequence 1,0,1,1,0,0, then a 1 proves the state returned to 00.
    vecs.push_back('{1'b1, 1'b1, 2'b11, "known0"});
    vecs.push_back('{1'b0, 1'b0, 2'b10, "known1"});
    vecs.push_back('{1'b0, 1'b1, 2'b00, "known2"});
    vecs.push_back('{1'b0, 1'b1, 2'b01, "known3"});
    vecs.push_back('{1'b0, 1'b0, 2'b01, "known4"});
    vecs.push_back('{1'b0, 1'b0, 2'b11, "known5"});
    vecs.push_back('{1'b0, 1'b1, 2'b11, "known_final_state00"});
    // All ones: 11, 01, then steady 10.
    vecs.push_back('{1'b1, 1'b1, 2'b11, "ones0"});
    vecs.push_back('{1'b0, 1'b1, 2'b01, "ones1"});
    vecs.push_back('{1'b0, 1'b1, 2'b10, "ones2"});
    vecs.push_back('{1'b0, 1'b1, 2'b10, "ones3"});
    vecs.push_back('{1'b0, 1'b1, 2'b10, "ones4"});
    // Reset mid-stream from state 11: next 1 encodes from 00.
    vecs.push_back('{1'b1, 1'b1, 2'b11, "midrst0"});
    vecs.push_back('{1'b0, 1'b1, 2'b01, "midrst1"});
    vecs.push_back('{1'b1, 1'b1, 2'b11, "midrst_after"});

    // Reset state.
    #3;
    check("reset_state", cout, 2'b00);
    @(posedge ck);
    #1;
    rset = 1'b1;

    // Build nonzero state/symbol, then assert reset mid-cycle with no edge.
    step(1'b1, "pre_async0", 2'b11);
    step(1'b1, "pre_async1", 2'b01);
    #2;
    rset = 1'b0;
    #1;
    check("async_clear", cout, 2'b00);
    h1 = 0;
    h2 = 0;
    // Held in reset while bin toggles across edges.
    for (int i = 0; i < 3; i++) begin
      bin = ~bin;
      @(posedge ck);
      #1;
      check("reset_hold", cout, 2'b00);
    end
    rset = 1'b1;
    // First bit after release sees state 00.
    step(1'b1, "first_after_release", 2'b11);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst_first) reset_pulse();
      step(vecs[i].b, vecs[i].name, vecs[i].exp);
    end

    // All-zero input for 8 cycles after reset.
    reset_pulse();
    for (int i = 0; i < 8; i++) step(1'b0, "zeros", 2'b00);

    // Randomized stream against the reference model, with occasional resets.
    reset_pulse();
    for (int i = 0; i < 400; i++) begin
      bit         b;
      logic [1:0] e;
      if ($urandom_range(0, 39) == 0) reset_pulse();
      b = 1'($urandom_range(0, 1));
      e = model_sym(int'(b));
      step(b, "random", e);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
